// File: rtl/fetch_pkg.sv
// Shared types and constants for the dual-issue fetch front end.
//   IMEM_BASE / IMEM_LAST : first and last word address of the IMEM window
//   fetch_entry_t         : one queued {pc, instr} pair
//   dec_take_t            : decode consumption code (00 none, 01 one, 11 two)
package fetch_pkg;

  localparam logic [31:0] IMEM_BASE = 32'h8000_0000;
  localparam logic [31:0] IMEM_LAST = 32'h8000_FFFC;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    TAKE_NONE = 2'b00,
    TAKE_ONE  = 2'b01,
    TAKE_TWO  = 2'b11
  } dec_take_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order circular buffer between fetch and decode.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : empty the queue (pointers and count to 0)
//   push_cnt   : entries to write this cycle (0..2); caller guarantees space
//   push0/1    : entries written at wr_ptr / wr_ptr+1
//   pop_cnt    : entries requested by the consumer (0..2); clamped to count
//   head0/1    : entries at rd_ptr / rd_ptr+1
//   count      : occupancy, 0..QDEPTH
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [1:0]                push_cnt,
  input  fetch_entry_t              push0,
  input  fetch_entry_t              push1,
  input  logic [1:0]                pop_cnt,
  output fetch_entry_t              head0,
  output fetch_entry_t              head1,
  output logic [$clog2(QDEPTH):0]   count
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t  mem [QDEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr_p1;
  logic [PW-1:0] wr_ptr_p1;
  logic [1:0]    pop_eff;

  assign rd_ptr_p1 = rd_ptr + PW'(1);
  assign wr_ptr_p1 = wr_ptr + PW'(1);

  assign head0 = mem[rd_ptr];
  assign head1 = mem[rd_ptr_p1];

  // Over-requested pops only drain what is actually present.
  always_comb begin
    pop_eff = pop_cnt;
    if (CW'(pop_cnt) > count) pop_eff = count[1:0];
  end

  always_ff @(posedge clk) begin
    if (push_cnt != 2'd0) mem[wr_ptr]    <= push0;
    if (push_cnt == 2'd2) mem[wr_ptr_p1] <= push1;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_cnt);
      rd_ptr <= rd_ptr + PW'(pop_eff);
      count  <= count + CW'(push_cnt) - CW'(pop_eff);
    end
  end

endmodule

// File: rtl/dual_fetch_unit.sv
// Front-end fetch stage of the dual-issue RV32 core.
// Drives a word-aligned fetch PC to a zero-latency dual-read IMEM, queues the
// returned {pc, instr} pairs and presents up to two of them per cycle to decode.
//   clk, rst            : clock, synchronous active-high reset
//   imem_addr           : fetch PC (IMEM port A)
//   imem_rd1/imem_rd2   : instructions at imem_addr and imem_addr+4
//   redirect_valid/_pc  : flush queue and restart fetch (pc bits [1:0] dropped)
//   dec_take            : entries consumed by decode (00/01/11; 10 acts as 00)
//   out0_* / out1_*     : oldest / second queue entry, zeroed when invalid
//   stall_cnt           : cycles without fetch (only with FETCH_STALL_CNT_EN)
module dual_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned QDEPTH    = 4,
  parameter logic [31:0] RESET_PC  = fetch_pkg::IMEM_BASE,
  parameter logic [31:0] IMEM_LAST = fetch_pkg::IMEM_LAST
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd1,
  input  logic [31:0] imem_rd2,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic [1:0]  dec_take,
  output logic        out0_valid,
  output logic [31:0] out0_pc,
  output logic [31:0] out0_instr,
  output logic        out1_valid,
  output logic [31:0] out1_pc,
  output logic [31:0] out1_instr
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  logic [31:0]   pc;
  logic [CW-1:0] q_count;
  logic [CW-1:0] free_slots;
  logic          fetch_en;
  logic          at_last;
  logic [1:0]    push_cnt;
  logic [1:0]    pop_cnt;
  fetch_entry_t  push0;
  fetch_entry_t  push1;
  fetch_entry_t  head0;
  fetch_entry_t  head1;

  assign imem_addr  = pc;
  assign free_slots = CW'(QDEPTH) - q_count;
  // Registered occupancy only, so dec_take never reaches imem_addr combinationally.
  assign fetch_en   = (free_slots >= CW'(2)) && !redirect_valid;
  assign at_last    = (pc == IMEM_LAST);

  assign push0    = '{pc: pc,          instr: imem_rd1};
  assign push1    = '{pc: pc + 32'd4,  instr: imem_rd2};
  assign push_cnt = !fetch_en ? 2'd0 : (at_last ? 2'd1 : 2'd2);

  always_comb begin
    pop_cnt = 2'd0;
    if (!redirect_valid) begin
      case (dec_take)
        TAKE_ONE: pop_cnt = 2'd1;
        TAKE_TWO: pop_cnt = 2'd2;
        default:  pop_cnt = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_pc & ~32'd3;
    end else if (fetch_en) begin
      pc <= at_last ? RESET_PC : pc + 32'd8;
    end
  end

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push_cnt (push_cnt),
    .push0    (push0),
    .push1    (push1),
    .pop_cnt  (pop_cnt),
    .head0    (head0),
    .head1    (head1),
    .count    (q_count)
  );

  assign out0_valid = (q_count != '0);
  assign out1_valid = (q_count >= CW'(2));
  assign out0_pc    = out0_valid ? head0.pc    : '0;
  assign out0_instr = out0_valid ? head0.instr : '0;
  assign out1_pc    = out1_valid ? head1.pc    : '0;
  assign out1_instr = out1_valid ? head1.instr : '0;

`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!fetch_en) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dual_fetch_unit.sv
// Directed self-checking bench for dual_fetch_unit (QDEPTH=4).
// IMEM returns instr(a) = {~a[15:0], a[15:0]} so every instruction identifies its PC.
// Optional stall counter checks are compiled in with FETCH_STALL_CNT_EN.
module tb_dual_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd1;
  logic [31:0] imem_rd2;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  dec_take;
  logic        out0_valid;
  logic [31:0] out0_pc;
  logic [31:0] out0_instr;
  logic        out1_valid;
  logic [31:0] out1_pc;
  logic [31:0] out1_instr;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  assign imem_rd1 = instr_of(imem_addr);
  assign imem_rd2 = instr_of(imem_addr + 32'd4);

  dual_fetch_unit #(
    .QDEPTH    (4),
    .RESET_PC  (32'h8000_0000),
    .IMEM_LAST (32'h8000_FFFC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rd1       (imem_rd1),
    .imem_rd2       (imem_rd2),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_take       (dec_take),
    .out0_valid     (out0_valid),
    .out0_pc        (out0_pc),
    .out0_instr     (out0_instr),
    .out1_valid     (out1_valid),
    .out1_pc        (out1_pc),
    .out1_instr     (out1_instr)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cnt      (stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Structural invariants sampled every cycle outside reset.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      assert (!(out1_valid && !out0_valid)) else begin
        failures++;
        $error("FAIL valid_order observed=%b%b expected=not_01", out1_valid, out0_valid);
      end
      checks++;
      assert (int'(dut.q_count) <= 4) else begin
        failures++;
        $error("FAIL count_bound observed=%0d expected=<=4", dut.q_count);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    dec_take       = 2'b00;
    step();
    step();

    // Reset state
    check("rst_out0_valid", {31'd0, out0_valid}, 32'd0);
    check("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
    check("rst_out0_pc",    out0_pc,    32'd0);
    check("rst_out0_instr", out0_instr, 32'd0);
    check("rst_out1_pc",    out1_pc,    32'd0);
    check("rst_imem_addr",  imem_addr,  32'h8000_0000);

    // Fill with decode idle: two pair fetches, then full
    rst = 1'b0;
    step();
    check("fill1_imem",       imem_addr, 32'h8000_0008);
    check("fill1_out0_valid", {31'd0, out0_valid}, 32'd1);
    check("fill1_out0_pc",    out0_pc,    32'h8000_0000);
    check("fill1_out0_instr", out0_instr, instr_of(32'h8000_0000));
    check("fill1_out1_pc",    out1_pc,    32'h8000_0004);
    check("fill1_out1_instr", out1_instr, instr_of(32'h8000_0004));
    step();
    check("fill2_imem", imem_addr, 32'h8000_0010);
    step();
    check("full_imem_hold", imem_addr, 32'h8000_0010);
    check("full_out0_pc",   out0_pc,   32'h8000_0000);
    check("full_out1_pc",   out1_pc,   32'h8000_0004);

    // Steady drain: one pair consumed and one fetched per cycle
    dec_take = 2'b11;
    for (int i = 0; i < 5; i++) begin
      step();
      check("drain_out0_pc",    out0_pc,    32'h8000_0008 + 32'(8 * i));
      check("drain_out1_pc",    out1_pc,    32'h8000_000C + 32'(8 * i));
      check("drain_out1_instr", out1_instr, instr_of(32'h8000_000C + 32'(8 * i)));
      check("drain_out1_valid", {31'd0, out1_valid}, 32'd1);
      check("drain_imem",       imem_addr,  32'h8000_0010 + 32'(8 * i));
    end

    // Refill to full and hold
    dec_take = 2'b00;
    step();
    step();
    check("hold_imem",    imem_addr, 32'h8000_0038);
    check("hold_out0_pc", out0_pc,   32'h8000_0028);
`ifdef FETCH_STALL_CNT_EN
    check("stall_before", stall_cnt, 32'd3);
    for (int i = 0; i < 10; i++) step();
    check("stall_after10", stall_cnt, 32'd13);
`endif

    // Redirect while full, with pops requested in the same cycle
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0107;
    dec_take       = 2'b11;
    step();
    check("redir_out0_valid", {31'd0, out0_valid}, 32'd0);
    check("redir_out1_valid", {31'd0, out1_valid}, 32'd0);
    check("redir_imem",       imem_addr, 32'h8000_0104);
    redirect_valid = 1'b0;
    dec_take       = 2'b00;
    step();
    check("redir2_out0_pc",    out0_pc,    32'h8000_0104);
    check("redir2_out0_instr", out0_instr, instr_of(32'h8000_0104));
    check("redir2_out1_pc",    out1_pc,    32'h8000_0108);
    check("redir2_imem",       imem_addr,  32'h8000_010C);

    // Redirect to the last IMEM word: single push and wrap
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_FFFC;
    step();
    check("last_imem", imem_addr, 32'h8000_FFFC);
    redirect_valid = 1'b0;
    dec_take       = 2'b11;          // queue empty: must be ignored
    step();
    check("last_out0_valid", {31'd0, out0_valid}, 32'd1);
    check("last_out0_pc",    out0_pc,    32'h8000_FFFC);
    check("last_out0_instr", out0_instr, instr_of(32'h8000_FFFC));
    check("last_out1_valid", {31'd0, out1_valid}, 32'd0);
    check("last_out1_pc",    out1_pc,    32'd0);
    check("wrap_imem",       imem_addr,  32'h8000_0000);
    dec_take = 2'b00;
    step();
    check("wrap_out0_pc", out0_pc, 32'h8000_FFFC);
    check("wrap_out1_pc", out1_pc, 32'h8000_0000);
    check("wrap_imem2",   imem_addr, 32'h8000_0008);

    // Single pop (count 3, no fetch)
    dec_take = 2'b01;
    step();
    check("pop1_out0_pc", out0_pc,   32'h8000_0000);
    check("pop1_out1_pc", out1_pc,   32'h8000_0004);
    check("pop1_imem",    imem_addr, 32'h8000_0008);

    // Illegal 10 acts as no pop; fetch proceeds (count 2 -> 4)
    dec_take = 2'b10;
    step();
    check("take10_out0_pc", out0_pc,   32'h8000_0000);
    check("take10_out1_pc", out1_pc,   32'h8000_0004);
    check("take10_imem",    imem_addr, 32'h8000_0010);

    // Drain down to a single entry
    dec_take = 2'b01;
    step();
    check("dn1_out0_pc", out0_pc, 32'h8000_0004);
    dec_take = 2'b11;
    step();
    check("dn2_out0_pc",     out0_pc, 32'h8000_000C);
    check("dn2_out1_valid",  {31'd0, out1_valid}, 32'd0);
    // Pop two with one present: clamped, plus a pair fetch
    step();
    check("clamp_out0_pc", out0_pc,   32'h8000_0010);
    check("clamp_out1_pc", out1_pc,   32'h8000_0014);
    check("clamp_imem",    imem_addr, 32'h8000_0018);
    dec_take = 2'b00;

    // Reset overrides a simultaneous redirect
    rst            = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    step();
    check("rst_redir_imem",  imem_addr, 32'h8000_0000);
    check("rst_redir_valid", {31'd0, out0_valid}, 32'd0);
`ifdef FETCH_STALL_CNT_EN
    check("rst_stall", stall_cnt, 32'd0);
`endif
    rst            = 1'b0;
    redirect_valid = 1'b0;
    step();
    check("post_rst_out0_pc", out0_pc, 32'h8000_0000);
    check("post_rst_out1_pc", out1_pc, 32'h8000_0004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
